// File: rtl/m3_commutation_step_gen_if.sv
// Bus bundle between the speed calculator (master) and the six-step commutation sequencer (slave).
interface m3_commutation_step_gen_if #(
  parameter int PERIOD_W = 32
);
  logic                workingI;
  logic [PERIOD_W-1:0] roundLenI;
  logic                m3invRotateI;
  logic                m3forceStopI;
  logic [2:0]          stepO;
  logic [2:0]          phaseHighO;
  logic [2:0]          phaseLowO;
  logic                nextRoundO;
  logic                busyO;

  modport master (
    output workingI, roundLenI, m3invRotateI, m3forceStopI,
    input  stepO, phaseHighO, phaseLowO, nextRoundO, busyO
  );

  modport slave (
    input  workingI, roundLenI, m3invRotateI, m3forceStopI,
    output stepO, phaseHighO, phaseLowO, nextRoundO, busyO
  );
endinterface

// File: rtl/m3_commutation_step_gen.sv
// Six-step commutation sequencer with per-step dead time and revolution pulse.
// Optional dynamic brake in STOP when M3_BRAKE_EN is defined (coast otherwise).
//
// state | meaning
// IDLE  | not working, all phases off, step 0
// DEAD  | first DEAD_CYCLES cycles of a step, all phases off
// DRIVE | remainder of the step, phase pattern of the current step
// STOP  | force-stopped: step and counter frozen, coast or brake
module m3_commutation_step_gen #(
  parameter int PERIOD_W    = 32,
  parameter int PERIOD_MIN  = 40,
  parameter int DEAD_CYCLES = 8
) (
  input  logic                       clkI,
  input  logic                       nRstI,
  m3_commutation_step_gen_if.slave   bus
);
  localparam int DW = $clog2(DEAD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DEAD, DRIVE, STOP} stateT;

  stateT               stateQ, stateD;
  logic [2:0]          stepQ, stepD;
  logic [PERIOD_W-1:0] cntQ, cntD;
  logic [DW-1:0]       deadQ, deadD;
  logic [2:0]          highQ, highD;
  logic [2:0]          lowQ, lowD;
  logic                roundQ, roundD;
  logic                busyQ, busyD;

  logic [PERIOD_W-1:0] stepLen;
  logic [2:0]          stepNext;
  logic                wrap;
  logic [5:0]          drivePat;

  // {high, low} enables, each as {C,B,A}
  function automatic logic [5:0] stepPattern(input logic [2:0] s);
    case (s)
      3'd0:    stepPattern = {3'b001, 3'b010};
      3'd1:    stepPattern = {3'b001, 3'b100};
      3'd2:    stepPattern = {3'b010, 3'b100};
      3'd3:    stepPattern = {3'b010, 3'b001};
      3'd4:    stepPattern = {3'b100, 3'b001};
      3'd5:    stepPattern = {3'b100, 3'b010};
      default: stepPattern = 6'b0;
    endcase
  endfunction

  always_comb begin
    stepLen  = (bus.roundLenI < PERIOD_W'(PERIOD_MIN)) ? PERIOD_W'(PERIOD_MIN) : bus.roundLenI;
    drivePat = stepPattern(stepQ);
    if (bus.m3invRotateI) begin
      stepNext = (stepQ == 3'd0) ? 3'd5 : stepQ - 3'd1;
      wrap     = (stepQ == 3'd0);
    end else begin
      stepNext = (stepQ == 3'd5) ? 3'd0 : stepQ + 3'd1;
      wrap     = (stepQ == 3'd5);
    end
  end

  always_ff @(posedge clkI) begin
    if (!nRstI) begin
      stateQ <= IDLE;
      stepQ  <= 3'd0;
      cntQ   <= '0;
      deadQ  <= '0;
      highQ  <= 3'b0;
      lowQ   <= 3'b0;
      roundQ <= 1'b0;
      busyQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      stepQ  <= stepD;
      cntQ   <= cntD;
      deadQ  <= deadD;
      highQ  <= highD;
      lowQ   <= lowD;
      roundQ <= roundD;
      busyQ  <= busyD;
    end
  end

  always_comb begin
    stateD = stateQ;
    stepD  = stepQ;
    cntD   = cntQ;
    deadD  = deadQ;
    highD  = 3'b0;
    lowD   = 3'b0;
    roundD = 1'b0;

    if (!bus.workingI) begin
      stateD = IDLE;
      stepD  = 3'd0;
      cntD   = '0;
      deadD  = '0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (!bus.m3forceStopI) begin
            stateD = DEAD;
            stepD  = 3'd0;
            cntD   = stepLen - PERIOD_W'(1);
            deadD  = DW'(DEAD_CYCLES - 1);
          end
        end
        DEAD, DRIVE: begin
          if (bus.m3forceStopI) begin
            stateD = STOP;
            deadD  = DW'(DEAD_CYCLES - 1);
          end else if (cntQ == '0) begin
            stateD = DEAD;
            stepD  = stepNext;
            cntD   = stepLen - PERIOD_W'(1);
            deadD  = DW'(DEAD_CYCLES - 1);
            roundD = wrap;
          end else begin
            cntD = cntQ - PERIOD_W'(1);
            if (stateQ == DRIVE || deadQ == '0) begin
              stateD        = DRIVE;
              {highD, lowD} = drivePat;
            end else begin
              deadD = deadQ - DW'(1);
            end
          end
        end
        STOP: begin
          if (!bus.m3forceStopI) begin
            stateD = DEAD;
            cntD   = stepLen - PERIOD_W'(1);
            deadD  = DW'(DEAD_CYCLES - 1);
          end else if (deadQ != '0) begin
            deadD = deadQ - DW'(1);
          end else begin
`ifdef M3_BRAKE_EN
            lowD = 3'b111;
`else
            lowD = 3'b000;
`endif
          end
        end
        default: stateD = IDLE;
      endcase
    end

    busyD = (stateD == DEAD) || (stateD == DRIVE);
  end

  assign bus.stepO      = stepQ;
  assign bus.phaseHighO = highQ;
  assign bus.phaseLowO  = lowQ;
  assign bus.nextRoundO = roundQ;
  assign bus.busyO      = busyQ;
endmodule

// File: tb/tb_m3_commutation_step_gen.sv
// Directed bench for m3_commutation_step_gen: expected output vectors are queued per cycle
// when stimulus is applied and compared when the simulation reaches that cycle.
module tb_m3_commutation_step_gen;
  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  m3_commutation_step_gen_if #(.PERIOD_W(32)) bus ();

  m3_commutation_step_gen #(.PERIOD_W(32), .PERIOD_MIN(40), .DEAD_CYCLES(8)) dut (
    .clkI  (clk),
    .nRstI (nRst),
    .bus   (bus)
  );

  typedef struct {
    int          at;
    logic [10:0] v;
  } entT;

  entT   sb[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    t0 = 0;
  int    nrCount = 0;
  int    overlap = 0;
  string scen = "reset";

  localparam logic [5:0] OFF = 6'b0;
`ifdef M3_BRAKE_EN
  localparam logic [5:0] BRK = 6'b000_111;
`else
  localparam logic [5:0] BRK = 6'b000_000;
`endif

  function automatic logic [5:0] pat(input int s);
    logic [5:0] tbl [6];
    tbl = '{6'b001_010, 6'b001_100, 6'b010_100, 6'b010_001, 6'b100_001, 6'b100_010};
    return tbl[s];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ex(input int at, input int st, input logic [5:0] hl, input logic nr, input logic bz);
    entT e;
    e.at = at;
    e.v  = {st[2:0], hl, nr, bz};
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (bus.nextRoundO) nrCount++;
    if ((bus.phaseHighO & bus.phaseLowO) != 3'b0) overlap++;
  endtask

  task automatic runTo(input int endAt);
    logic [10:0] obs;
    while (cyc < endAt) begin
      tick();
      obs = {bus.stepO, bus.phaseHighO, bus.phaseLowO, bus.nextRoundO, bus.busyO};
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at == cyc) begin
          chk($sformatf("%s@%0d", scen, sb[i].at - t0), {21'b0, obs}, {21'b0, sb[i].v});
          sb.delete(i);
        end
      end
    end
  endtask

  task automatic startRun(input int len, input logic inv);
    bus.roundLenI    = len;
    bus.m3invRotateI = inv;
    bus.m3forceStopI = 1'b0;
    bus.workingI     = 1'b1;
    t0      = cyc + 1;
    nrCount = 0;
  endtask

  task automatic goIdle();
    bus.workingI     = 1'b0;
    bus.m3forceStopI = 1'b0;
    ex(cyc + 1, 0, OFF, 1'b0, 1'b0);
    runTo(cyc + 2);
  endtask

  initial begin
    nRst             = 1'b0;
    bus.workingI     = 1'b0;
    bus.roundLenI    = 32'd100;
    bus.m3invRotateI = 1'b0;
    bus.m3forceStopI = 1'b0;

    // reset values
    ex(2, 0, OFF, 1'b0, 1'b0);
    runTo(3);
    nRst = 1'b1;
    runTo(5);

    // forward run, L=100
    scen = "fwd";
    startRun(100, 1'b0);
    for (int k = 0; k <= 6; k++) begin
      ex(t0 + k*100,     k % 6, OFF,        k == 6, 1'b1);
      ex(t0 + k*100 + 7, k % 6, OFF,        1'b0,   1'b1);
      ex(t0 + k*100 + 8, k % 6, pat(k % 6), 1'b0,   1'b1);
      if (k < 6) ex(t0 + k*100 + 99, k, pat(k), 1'b0, 1'b1);
    end
    ex(t0 + 601, 0, OFF, 1'b0, 1'b1);
    runTo(t0 + 650);
    chk("fwd_pulses", nrCount, 1);
    goIdle();

    // clamp and mid-step length changes
    scen = "len";
    startRun(5, 1'b0);
    ex(t0,      0, OFF,    1'b0, 1'b1);
    ex(t0 + 8,  0, pat(0), 1'b0, 1'b1);
    ex(t0 + 39, 0, pat(0), 1'b0, 1'b1);
    ex(t0 + 40, 1, OFF,    1'b0, 1'b1);
    runTo(t0 + 50);
    bus.roundLenI = 32'd100;
    ex(t0 + 79, 1, pat(1), 1'b0, 1'b1);
    ex(t0 + 80, 2, OFF,    1'b0, 1'b1);
    runTo(t0 + 100);
    bus.roundLenI = 32'd60;
    ex(t0 + 179, 2, pat(2), 1'b0, 1'b1);
    ex(t0 + 180, 3, OFF,    1'b0, 1'b1);
    ex(t0 + 239, 3, pat(3), 1'b0, 1'b1);
    ex(t0 + 240, 4, OFF,    1'b0, 1'b1);
    runTo(t0 + 245);
    goIdle();

    // inverse rotation, then direction toggle mid-step
    scen = "inv";
    startRun(100, 1'b1);
    ex(t0,       0, OFF,    1'b0, 1'b1);
    ex(t0 + 99,  0, pat(0), 1'b0, 1'b1);
    ex(t0 + 100, 5, OFF,    1'b1, 1'b1);
    ex(t0 + 101, 5, OFF,    1'b0, 1'b1);
    ex(t0 + 108, 5, pat(5), 1'b0, 1'b1);
    ex(t0 + 200, 4, OFF,    1'b0, 1'b1);
    runTo(t0 + 250);
    bus.m3invRotateI = 1'b0;
    ex(t0 + 300, 5, OFF, 1'b0, 1'b1);
    ex(t0 + 400, 0, OFF, 1'b1, 1'b1);
    runTo(t0 + 405);
    goIdle();

    // force stop during step 3 DRIVE, then force stop on the step's last cycle
    scen = "stop";
    startRun(100, 1'b0);
    ex(t0 + 308, 3, pat(3), 1'b0, 1'b1);
    runTo(t0 + 320);
    bus.m3forceStopI = 1'b1;
    ex(t0 + 321, 3, OFF, 1'b0, 1'b0);
    ex(t0 + 328, 3, OFF, 1'b0, 1'b0);
    ex(t0 + 329, 3, BRK, 1'b0, 1'b0);
    ex(t0 + 340, 3, BRK, 1'b0, 1'b0);
    runTo(t0 + 340);
    bus.m3forceStopI = 1'b0;
    ex(t0 + 341, 3, OFF,    1'b0, 1'b1);
    ex(t0 + 348, 3, OFF,    1'b0, 1'b1);
    ex(t0 + 349, 3, pat(3), 1'b0, 1'b1);
    ex(t0 + 440, 3, pat(3), 1'b0, 1'b1);
    ex(t0 + 441, 4, OFF,    1'b0, 1'b1);
    runTo(t0 + 540);
    bus.m3forceStopI = 1'b1;
    ex(t0 + 541, 4, OFF, 1'b0, 1'b0);
    runTo(t0 + 545);
    bus.m3forceStopI = 1'b0;
    ex(t0 + 546, 4, OFF,    1'b0, 1'b1);
    ex(t0 + 554, 4, pat(4), 1'b0, 1'b1);
    ex(t0 + 645, 4, pat(4), 1'b0, 1'b1);
    ex(t0 + 646, 5, OFF,    1'b0, 1'b1);
    runTo(t0 + 650);
    chk("stop_pulses", nrCount, 0);
    goIdle();

    // synchronous reset one cycle before the revolution wrap
    scen = "rst";
    startRun(100, 1'b0);
    ex(t0 + 598, 5, pat(5), 1'b0, 1'b1);
    runTo(t0 + 598);
    nRst = 1'b0;
    ex(t0 + 599, 0, OFF, 1'b0, 1'b0);
    ex(t0 + 600, 0, OFF, 1'b0, 1'b0);
    ex(t0 + 601, 0, OFF, 1'b0, 1'b0);
    runTo(t0 + 601);
    nRst = 1'b1;
    ex(t0 + 602, 0, OFF,    1'b0, 1'b1);
    ex(t0 + 610, 0, pat(0), 1'b0, 1'b1);
    runTo(t0 + 620);
    chk("rst_pulses", nrCount, 0);

    chk("no_overlap", overlap, 0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
